rca_writeback_queue: RTL and testbench
======================================

RCA_WRITEBACK_QUEUE -- requirements
Module: rca_writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning result-queue entries (power of two, >= 2).
REQ-002 The block SHALL take NUM_WRITE_PORTS from taiga_config and id_t from taiga_types.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port rca_done  in  1  RCA result valid; upstream holds it until accepted.
REQ-006 The block SHALL have port rca_done_id  in  id_t  ID of the completing RCA instruction.
REQ-007 The block SHALL have port rca_done_data  in  32 x NUM_WRITE_PORTS  per-port result data.
REQ-008 The block SHALL have port rca_ack  out  1  result accepted this cycle.
REQ-009 The block SHALL have port wb_grant  in  1  register-file RCA commit slot available this cycle.
REQ-010 The block SHALL have port rca_id_retiring  out  id_t  head-entry ID, to the metadata block.
REQ-011 The block SHALL have port rca_retired  out  1  head entry retires this cycle.
REQ-012 The block SHALL have port rca_retired_rd_addrs  in  5 x NUM_WRITE_PORTS  rd addresses for rca_id_retiring, returned combinationally.
REQ-013 The block SHALL have port rca_id_for_rds  in  id_t x NUM_WRITE_PORTS  latest-writer ID per returned rd.
REQ-014 The block SHALL have port rf_we  out  NUM_WRITE_PORTS  per-port register-file write enable.
REQ-015 The block SHALL have port rf_waddr  out  5 x NUM_WRITE_PORTS  register-file write address.
REQ-016 The block SHALL have port rf_wdata  out  32 x NUM_WRITE_PORTS  register-file write data.
REQ-017 The block SHALL have port occupancy  out  $clog2(DEPTH)+1  valid-entry count.

Function
REQ-018 rca_ack SHALL equal rca_done & (occupancy != DEPTH), combinationally; when full, no push occurs, even if a pop happens in the same cycle.
REQ-019 An accepted result SHALL be written at the tail and SHALL become visible at the head no earlier than the next cycle; there is no same-cycle bypass.
REQ-020 rca_id_retiring SHALL show the head ID whenever occupancy != 0, and 0 otherwise.
REQ-021 rca_retired SHALL equal (occupancy != 0) & wb_grant; each retire pops exactly one entry.
REQ-022 rf_waddr[i] SHALL equal rca_retired_rd_addrs[i], and rf_wdata[i] SHALL equal the head data for port i.
REQ-023 rf_we[i] SHALL equal rca_retired & (rf_waddr[i] != 0) & (rca_id_for_rds[i] == rca_id_retiring) & no lower port j<i with rf_we-eligible equal rf_waddr[j].
REQ-024 A suppressed port SHALL still count as retired; the ID is freed regardless.
REQ-025 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; occupancy SHALL saturate at neither bound, so any overflow or underflow is a design error.
REQ-027 At most one push and one pop SHALL occur per cycle.

Reset
REQ-028 On rst assertion, head pointer, tail pointer and occupancy SHALL clear immediately; rca_retired, rca_ack and rf_we then read 0.
REQ-029 Queue data storage SHALL NOT be reset.
REQ-030 A result presented during reset SHALL NOT be accepted.

Structure
REQ-031 typedef rca_wb_entry_t {id_t id; logic [31:0] data[NUM_WRITE_PORTS]} SHALL live in taiga_types.
REQ-032 Storage SHALL be one sub-module, rca_wb_fifo (DEPTH-parameterised LUTRAM FIFO with push/pop/full/empty).
REQ-033 Port-priority and rd filtering SHALL be combinational logic in the top module.
REQ-034 Assertions SHALL check: no pop when empty, and rca_ack never asserted while full.

Verification
REQ-035 Scenario: push id=3, data {0xA,0xB}, rds {5,6}, id_for_rds {3,3}, wb_grant=1 the next cycle -> rca_retired=1, rf_we=2'b11, rf_wdata={0xA,0xB}.
REQ-036 Scenario: rds {0,7} -> rf_we=2'b10; rds {9,9} -> rf_we=2'b01.
REQ-037 Scenario: id_for_rds[0]=8 while the head id=3 -> rf_we[0]=0, rca_retired=1, occupancy decrements.
REQ-038 Scenario: 4 pushes with wb_grant=0 -> occupancy=4, and a 5th rca_done gets rca_ack=0; then push+pop the same cycle at occupancy=2 -> occupancy stays 2, and FIFO order is preserved across the wrap.
REQ-039 Scenario: assert rst asynchronously mid-cycle with 3 entries -> occupancy=0 and rca_retired=0 before the next edge; after release, a push of id=1 retires as id=1.

Source files
------------

// File: rtl/rca_writeback_queue_pkg.sv
// ============================================================================
// Module : taiga_config / taiga_types (packages)
// Brief  : Shared configuration and types for the RCA writeback queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package taiga_config;
    localparam int NUM_WRITE_PORTS = 2;
endpackage

package taiga_types;
    import taiga_config::*;

    typedef logic [3:0] id_t;

    // Data is kept packed so one entry maps onto a single LUTRAM word.
    typedef struct packed {
        id_t                                id;
        logic [NUM_WRITE_PORTS-1:0][31:0]   data;
    } rca_wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/rca_wb_fifo.sv
// ============================================================================
// Module : rca_wb_fifo
// Brief  : DEPTH-entry LUTRAM FIFO of RCA results; storage is never reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_wb_fifo
    import taiga_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  rca_wb_entry_t               push_data,
    output rca_wb_entry_t               pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = DEPTH[c_PTR_W:0];

    rca_wb_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_PTR_W:0]       r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_tail] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + 1'b1;
            if (pop)  r_head <= r_head + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_head];
    assign full     = (r_count == c_FULL_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/rca_writeback_queue.sv
// ============================================================================
// Module : rca_writeback_queue
// Brief  : Queues RCA results and retires them into the register file with
//          per-port rd filtering and lowest-port priority on duplicate rds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_writeback_queue
    import taiga_config::*;
    import taiga_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rca_done,
    input  id_t                                 rca_done_id,
    input  logic [NUM_WRITE_PORTS-1:0][31:0]    rca_done_data,
    output logic                                rca_ack,
    input  logic                                wb_grant,
    output id_t                                 rca_id_retiring,
    output logic                                rca_retired,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]     rca_retired_rd_addrs,
    input  id_t  [NUM_WRITE_PORTS-1:0]          rca_id_for_rds,
    output logic [NUM_WRITE_PORTS-1:0]          rf_we,
    output logic [NUM_WRITE_PORTS-1:0][4:0]     rf_waddr,
    output logic [NUM_WRITE_PORTS-1:0][31:0]    rf_wdata,
    output logic [$clog2(DEPTH):0]              occupancy
);
    logic                           w_full;
    logic                           w_empty;
    rca_wb_entry_t                  w_push_entry;
    rca_wb_entry_t                  w_head;
    logic [NUM_WRITE_PORTS-1:0]     w_elig;

    // Gating on rst keeps a result held during reset from being acknowledged.
    assign rca_ack     = rca_done & ~w_full & ~rst;
    assign rca_retired = ~w_empty & wb_grant;

    assign w_push_entry.id   = rca_done_id;
    assign w_push_entry.data = rca_done_data;

    rca_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rca_ack),
        .pop       (rca_retired),
        .push_data (w_push_entry),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (occupancy)
    );

    assign rca_id_retiring = w_empty ? '0 : w_head.id;

    // A port writes only if rd is non-zero and this ID is still its latest writer.
    for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_port
        assign rf_waddr[i] = rca_retired_rd_addrs[i];
        assign rf_wdata[i] = w_head.data[i];
        assign w_elig[i]   = rca_retired & (rca_retired_rd_addrs[i] != 5'd0)
                           & (rca_id_for_rds[i] == rca_id_retiring);
    end

    always_comb begin
        rf_we = w_elig;
        for (int i = 1; i < NUM_WRITE_PORTS; i++) begin
            for (int j = 0; j < i; j++) begin
                if (w_elig[j] && (rca_retired_rd_addrs[j] == rca_retired_rd_addrs[i])) begin
                    rf_we[i] = 1'b0;
                end
            end
        end
    end

    a_no_ack_full: assert property (@(posedge clk) disable iff (rst) !(rca_ack && w_full));

endmodule

`default_nettype wire

// File: tb/tb_rca_writeback_queue.sv
// ============================================================================
// Module : tb_rca_writeback_queue
// Brief  : Directed self-checking bench for rca_writeback_queue (DEPTH=4, 2 ports).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rca_writeback_queue;
    import taiga_config::*;
    import taiga_types::*;

    logic                               clk;
    logic                               rst;
    logic                               rca_done;
    id_t                                rca_done_id;
    logic [NUM_WRITE_PORTS-1:0][31:0]   rca_done_data;
    logic                               rca_ack;
    logic                               wb_grant;
    id_t                                rca_id_retiring;
    logic                               rca_retired;
    logic [NUM_WRITE_PORTS-1:0][4:0]    rca_retired_rd_addrs;
    id_t  [NUM_WRITE_PORTS-1:0]         rca_id_for_rds;
    logic [NUM_WRITE_PORTS-1:0]         rf_we;
    logic [NUM_WRITE_PORTS-1:0][4:0]    rf_waddr;
    logic [NUM_WRITE_PORTS-1:0][31:0]   rf_wdata;
    logic [2:0]                         occupancy;

    int checks   = 0;
    int failures = 0;

    rca_writeback_queue #(.DEPTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rca_done             (rca_done),
        .rca_done_id          (rca_done_id),
        .rca_done_data        (rca_done_data),
        .rca_ack              (rca_ack),
        .wb_grant             (wb_grant),
        .rca_id_retiring      (rca_id_retiring),
        .rca_retired          (rca_retired),
        .rca_retired_rd_addrs (rca_retired_rd_addrs),
        .rca_id_for_rds       (rca_id_for_rds),
        .rf_we                (rf_we),
        .rf_waddr             (rf_waddr),
        .rf_wdata             (rf_wdata),
        .occupancy            (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input id_t id, input logic [31:0] d0, input logic [31:0] d1);
        rca_done         = 1'b1;
        rca_done_id      = id;
        rca_done_data[0] = d0;
        rca_done_data[1] = d1;
        step();
        rca_done = 1'b0;
    endtask

    task automatic set_rds(input logic [4:0] a0, input logic [4:0] a1, input id_t i0, input id_t i1);
        rca_retired_rd_addrs[0] = a0;
        rca_retired_rd_addrs[1] = a1;
        rca_id_for_rds[0]       = i0;
        rca_id_for_rds[1]       = i1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rca_done = 1'b1; rca_done_id = 4'd2; rca_done_data = '0;
        wb_grant = 1'b1; set_rds(5'd1, 5'd2, 4'd0, 4'd0);
        #2;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ actual=%0d expected=0", occupancy); end
        checks++; if (rca_ack !== 1'b0) begin failures++; $display("FAIL reset_ack actual=%b expected=0", rca_ack); end
        checks++; if (rca_retired !== 1'b0) begin failures++; $display("FAIL reset_retired actual=%b expected=0", rca_retired); end
        checks++; if (rf_we !== 2'b00) begin failures++; $display("FAIL reset_rf_we actual=%b expected=00", rf_we); end
        step();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_no_accept actual=%0d expected=0", occupancy); end
        rst = 1'b0; rca_done = 1'b0; wb_grant = 1'b0;
        #1;
        checks++; if (rca_id_retiring !== 4'd0) begin failures++; $display("FAIL reset_id actual=%0d expected=0", rca_id_retiring); end
    endtask

    task automatic test_basic_retire();
        set_rds(5'd5, 5'd6, 4'd3, 4'd3);
        wb_grant = 1'b1;
        rca_done = 1'b1; rca_done_id = 4'd3; rca_done_data[0] = 32'hA; rca_done_data[1] = 32'hB;
        #1;
        checks++; if (rca_ack !== 1'b1) begin failures++; $display("FAIL basic_ack actual=%b expected=1", rca_ack); end
        checks++; if (rca_retired !== 1'b0) begin failures++; $display("FAIL basic_no_bypass actual=%b expected=0", rca_retired); end
        step();
        rca_done = 1'b0;
        #1;
        checks++; if (rca_retired !== 1'b1) begin failures++; $display("FAIL basic_retired actual=%b expected=1", rca_retired); end
        checks++; if (rca_id_retiring !== 4'd3) begin failures++; $display("FAIL basic_id actual=%0d expected=3", rca_id_retiring); end
        checks++; if (rf_we !== 2'b11) begin failures++; $display("FAIL basic_rf_we actual=%b expected=11", rf_we); end
        checks++; if (rf_wdata[0] !== 32'hA || rf_wdata[1] !== 32'hB) begin failures++; $display("FAIL basic_wdata actual=%h/%h expected=a/b", rf_wdata[0], rf_wdata[1]); end
        checks++; if (rf_waddr[0] !== 5'd5 || rf_waddr[1] !== 5'd6) begin failures++; $display("FAIL basic_waddr actual=%0d/%0d expected=5/6", rf_waddr[0], rf_waddr[1]); end
        step();
        wb_grant = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL basic_occ actual=%0d expected=0", occupancy); end
        checks++; if (rca_id_retiring !== 4'd0) begin failures++; $display("FAIL basic_empty_id actual=%0d expected=0", rca_id_retiring); end
    endtask

    task automatic test_rd_filter();
        push(4'd4, 32'h11, 32'h22);
        set_rds(5'd0, 5'd7, 4'd4, 4'd4);
        wb_grant = 1'b1;
        #1;
        checks++; if (rf_we !== 2'b10) begin failures++; $display("FAIL filter_rd0 actual=%b expected=10", rf_we); end
        step();
        wb_grant = 1'b0;
        push(4'd5, 32'h33, 32'h44);
        set_rds(5'd9, 5'd9, 4'd5, 4'd5);
        wb_grant = 1'b1;
        #1;
        checks++; if (rf_we !== 2'b01) begin failures++; $display("FAIL filter_dup actual=%b expected=01", rf_we); end
        checks++; if (rca_retired !== 1'b1) begin failures++; $display("FAIL filter_dup_retired actual=%b expected=1", rca_retired); end
        step();
        wb_grant = 1'b0;
    endtask

    task automatic test_id_mismatch();
        push(4'd3, 32'h55, 32'h66);
        set_rds(5'd5, 5'd6, 4'd8, 4'd3);
        wb_grant = 1'b1;
        #1;
        checks++; if (rf_we !== 2'b10) begin failures++; $display("FAIL mismatch_rf_we actual=%b expected=10", rf_we); end
        checks++; if (rca_retired !== 1'b1) begin failures++; $display("FAIL mismatch_retired actual=%b expected=1", rca_retired); end
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL mismatch_occ_pre actual=%0d expected=1", occupancy); end
        step();
        wb_grant = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL mismatch_occ_post actual=%0d expected=0", occupancy); end
    endtask

    task automatic test_full_and_wrap();
        for (int k = 1; k <= 4; k++) begin
            push(id_t'(k), 32'(k * 16'h11), 32'(k * 16'h101));
        end
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ actual=%0d expected=4", occupancy); end
        rca_done = 1'b1; rca_done_id = 4'd9; rca_done_data[0] = 32'hDEAD; rca_done_data[1] = 32'hBEEF;
        #1;
        checks++; if (rca_ack !== 1'b0) begin failures++; $display("FAIL full_ack actual=%b expected=0", rca_ack); end
        wb_grant = 1'b1;
        #1;
        checks++; if (rca_ack !== 1'b0) begin failures++; $display("FAIL full_ack_with_pop actual=%b expected=0", rca_ack); end
        checks++; if (rca_id_retiring !== 4'd1) begin failures++; $display("FAIL full_head actual=%0d expected=1", rca_id_retiring); end
        step();
        rca_done = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL full_pop_occ actual=%0d expected=3", occupancy); end
        checks++; if (rca_id_retiring !== 4'd2) begin failures++; $display("FAIL pop2_id actual=%0d expected=2", rca_id_retiring); end
        step();
        // Head is now id 3 at occupancy 2; push id 5 while popping.
        rca_done = 1'b1; rca_done_id = 4'd5; rca_done_data[0] = 32'h55; rca_done_data[1] = 32'h505;
        #1;
        checks++; if (rca_ack !== 1'b1 || rca_retired !== 1'b1) begin failures++; $display("FAIL swap_handshake actual=%b%b expected=11", rca_ack, rca_retired); end
        checks++; if (rca_id_retiring !== 4'd3 || rf_wdata[0] !== 32'h33) begin failures++; $display("FAIL swap_head actual=%0d/%h expected=3/33", rca_id_retiring, rf_wdata[0]); end
        step();
        rca_done = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL swap_occ actual=%0d expected=2", occupancy); end
        checks++; if (rca_id_retiring !== 4'd4 || rf_wdata[1] !== 32'h404) begin failures++; $display("FAIL wrap_id4 actual=%0d/%h expected=4/404", rca_id_retiring, rf_wdata[1]); end
        step();
        checks++; if (rca_id_retiring !== 4'd5 || rf_wdata[0] !== 32'h55) begin failures++; $display("FAIL wrap_id5 actual=%0d/%h expected=5/55", rca_id_retiring, rf_wdata[0]); end
        step();
        wb_grant = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL wrap_drain actual=%0d expected=0", occupancy); end
    endtask

    task automatic test_async_reset();
        push(4'd6, 32'h6, 32'h6);
        push(4'd7, 32'h7, 32'h7);
        push(4'd2, 32'h2, 32'h2);
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL areset_pre_occ actual=%0d expected=3", occupancy); end
        #2;
        rst = 1'b1; wb_grant = 1'b1; rca_done = 1'b1; rca_done_id = 4'd9;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL areset_occ actual=%0d expected=0", occupancy); end
        checks++; if (rca_retired !== 1'b0 || rca_ack !== 1'b0 || rf_we !== 2'b00) begin failures++; $display("FAIL areset_outputs actual=%b%b%b expected=000", rca_retired, rca_ack, rf_we); end
        step();
        rst = 1'b0; rca_done = 1'b0; wb_grant = 1'b0;
        push(4'd1, 32'h1234, 32'h5678);
        set_rds(5'd3, 5'd4, 4'd1, 4'd1);
        wb_grant = 1'b1;
        #1;
        checks++; if (rca_id_retiring !== 4'd1 || rca_retired !== 1'b1) begin failures++; $display("FAIL areset_retire actual=%0d/%b expected=1/1", rca_id_retiring, rca_retired); end
        checks++; if (rf_we !== 2'b11 || rf_wdata[0] !== 32'h1234) begin failures++; $display("FAIL areset_write actual=%b/%h expected=11/1234", rf_we, rf_wdata[0]); end
        step();
        wb_grant = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL areset_final_occ actual=%0d expected=0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_basic_retire();
        test_rd_filter();
        test_id_mismatch();
        test_full_and_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
